// File: rtl/fft_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fft_seq
//  Purpose  : Top-level sequencer for an in-place radix-2 DIT FFT engine.
//             Loads N samples in bit-reversed address order, issues every
//             butterfly of every stage (draining the butterfly pipeline at
//             each stage boundary), streams the result out in natural
//             order and pulses done.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N        FFT points (power of 2, 8..1024)
//    LOG2N    log2(N)
//    MAX_OUT  max butterflies in flight (>= butterfly pipeline latency)
//  Ports
//    clk, rst_n            clock, asynchronous active-low reset
//    start                 single-cycle request, honoured only in IDLE
//    busy, done            status; done is a one-cycle pulse at the end
//    in_valid/in_ready     sample load handshake; load_addr = bitrev(load_cnt)
//    bf_ready/bf_issue     butterfly issue handshake
//    idx1, idx2, tw_addr   operand addresses and twiddle ROM address
//    stage                 current stage 0..LOG2N-1
//    bf_wb                 one pulse per completed butterfly writeback
//    out_valid/out_ready   result unload handshake; out_addr natural order
//    err                   sticky, set by a writeback with nothing in flight
//  Optional build macro
//    FFT_ABORT_EN          adds input 'abort': returns to IDLE from any
//                          non-IDLE state and discards in-flight butterflies
// ============================================================================
module fft_seq #(
  parameter int N       = 256,
  parameter int LOG2N   = 8,
  parameter int MAX_OUT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef FFT_ABORT_EN
  input  logic                       abort,
`endif
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [LOG2N-1:0]           load_addr,
  input  logic                       bf_ready,
  output logic                       bf_issue,
  output logic [LOG2N-1:0]           idx1,
  output logic [LOG2N-1:0]           idx2,
  output logic [LOG2N-2:0]           tw_addr,
  output logic [$clog2(LOG2N)-1:0]   stage,
  input  logic                       bf_wb,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LOG2N-1:0]           out_addr,
  output logic                       err
);

  localparam int SW = $clog2(LOG2N);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int KW = LOG2N - 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CALC   = 3'd2,
    S_DRAIN  = 3'd3,
    S_UNLOAD = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [LOG2N-1:0]  load_cnt;
  logic [KW-1:0]     k;
  logic [SW-1:0]     stage_q;
  logic [OW-1:0]     outstanding, outstanding_nxt;
  logic [LOG2N-1:0]  out_cnt;
  logic              err_q;

  logic              hs;
  logic              wb_ok;
  logic              err_set;
  logic              drain_empty;
  logic              abort_now;
  logic              wb_mask;

  // --------------------------------------------------------------------------
  // Optional abort
  // --------------------------------------------------------------------------
`ifdef FFT_ABORT_EN
  assign abort_now = abort && (state != S_IDLE);

  // After an abort, writebacks of discarded butterflies may still arrive;
  // they must not be reported as spurious until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_mask <= 1'b0;
    end else if (abort_now) begin
      wb_mask <= 1'b1;
    end else if (state == S_IDLE && start) begin
      wb_mask <= 1'b0;
    end
  end
`else
  assign abort_now = 1'b0;
  assign wb_mask   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Handshakes and in-flight accounting
  // --------------------------------------------------------------------------
  assign bf_issue = (state == S_CALC) && (outstanding != OW'(MAX_OUT));
  assign hs       = bf_issue && bf_ready;
  assign wb_ok    = bf_wb && (outstanding != '0);
  assign err_set  = bf_wb && (outstanding == '0) && !wb_mask;

  always_comb begin
    outstanding_nxt = outstanding;
    case ({hs, wb_ok})
      2'b10:   outstanding_nxt = outstanding + OW'(1);
      2'b01:   outstanding_nxt = outstanding - OW'(1);
      default: outstanding_nxt = outstanding;
    endcase
  end

  // Drain completes in the same cycle the last writeback lands.
  assign drain_empty = (outstanding_nxt == '0);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD;
      S_LOAD:   if (in_valid && load_cnt == LOG2N'(N - 1)) state_nxt = S_CALC;
      S_CALC:   if (hs && k == KW'(N / 2 - 1)) state_nxt = S_DRAIN;
      S_DRAIN:  if (drain_empty) begin
                  state_nxt = (stage_q == SW'(LOG2N - 1)) ? S_UNLOAD : S_CALC;
                end
      S_UNLOAD: if (out_ready && out_cnt == LOG2N'(N - 1)) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort_now) state_nxt = S_IDLE;
  end

  // --------------------------------------------------------------------------
  // Counters. load_cnt and k are exactly log2 of their range, so they wrap
  // back to 0 on their last increment without an explicit compare.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt    <= '0;
      k           <= '0;
      stage_q     <= '0;
      outstanding <= '0;
      out_cnt     <= '0;
      err_q       <= 1'b0;
    end else if (abort_now) begin
      load_cnt    <= '0;
      k           <= '0;
      stage_q     <= '0;
      outstanding <= '0;
      out_cnt     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (err_set) err_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            load_cnt <= '0;
            k        <= '0;
            stage_q  <= '0;
            out_cnt  <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) load_cnt <= load_cnt + LOG2N'(1);
        end
        S_CALC: begin
          if (hs) k <= k + KW'(1);
        end
        S_DRAIN: begin
          if (drain_empty) begin
            if (stage_q != SW'(LOG2N - 1)) begin
              stage_q <= stage_q + SW'(1);
            end else begin
              out_cnt <= '0;
            end
          end
        end
        S_UNLOAD: begin
          if (out_ready) out_cnt <= out_cnt + LOG2N'(1);
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Butterfly addressing
  //   half = 1<<stage, j = k & (half-1), g = k >> stage
  //   idx1 = (g << (stage+1)) + j, idx2 = idx1 + half
  //   tw   = j << (LOG2N-1-stage)
  // Addresses are forced to 0 outside CALC so idle outputs read as zero.
  // --------------------------------------------------------------------------
  logic [LOG2N-1:0] k_ext, half, j, g, base, tw_full;

  always_comb begin
    k_ext   = {1'b0, k};
    half    = LOG2N'(1) << stage_q;
    j       = k_ext & (half - LOG2N'(1));
    g       = k_ext >> stage_q;
    base    = (g << (int'(stage_q) + 1)) + j;
    tw_full = j << (LOG2N - 1 - int'(stage_q));
  end

  assign idx1    = (state == S_CALC) ? base : '0;
  assign idx2    = (state == S_CALC) ? (base + half) : '0;
  assign tw_addr = (state == S_CALC) ? tw_full[LOG2N-2:0] : '0;

  // --------------------------------------------------------------------------
  // Bit-reversed load address
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < LOG2N; b++) begin : g_bitrev
    assign load_addr[b] = load_cnt[LOG2N-1-b];
  end

  // --------------------------------------------------------------------------
  // Status outputs
  // --------------------------------------------------------------------------
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_UNLOAD);
  assign out_addr  = out_cnt;
  assign stage     = stage_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_seq
//  Purpose  : Self-checking bench for fft_seq (N=8, LOG2N=3, MAX_OUT=2).
//             A butterfly-unit model returns each writeback 3 cycles after
//             its issue; expected butterfly order comes from the textbook
//             stage/group/element loops.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_seq;

  localparam int N       = 8;
  localparam int LOG2N   = 3;
  localparam int MAX_OUT = 2;
  localparam int SW      = $clog2(LOG2N);
  localparam int HALF    = N / 2;
  localparam int NBF     = LOG2N * HALF;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                in_valid = 1'b0;
  logic                bf_ready = 1'b0;
  logic                bf_wb = 1'b0;
  logic                out_ready = 1'b0;
`ifdef FFT_ABORT_EN
  logic                abort = 1'b0;
`endif
  logic                busy, done, in_ready, bf_issue, out_valid, err;
  logic [LOG2N-1:0]    load_addr, idx1, idx2, out_addr;
  logic [LOG2N-2:0]    tw_addr;
  logic [SW-1:0]       stage;

  fft_seq #(.N(N), .LOG2N(LOG2N), .MAX_OUT(MAX_OUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FFT_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .load_addr (load_addr),
    .bf_ready  (bf_ready),
    .bf_issue  (bf_issue),
    .idx1      (idx1),
    .idx2      (idx2),
    .tw_addr   (tw_addr),
    .stage     (stage),
    .bf_wb     (bf_wb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .err       (err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Butterfly-unit model: writeback arrives 3 cycles after the handshake.
  bit       wb_auto = 1'b0;
  bit       man_wb  = 1'b0;
  bit [2:0] dly     = '0;

  int e_i1 [NBF];
  int e_i2 [NBF];
  int e_tw [NBF];

  function automatic int bitrev(input int v);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) r = r * 2 + ((v >> b) & 1);
    return r;
  endfunction

  task automatic build_expected();
    int n = 0;
    for (int s = 0; s < LOG2N; s++) begin
      int half = 1 << s;
      int groups = N / (2 * half);
      for (int g = 0; g < groups; g++) begin
        for (int j = 0; j < half; j++) begin
          e_i1[n] = g * 2 * half + j;
          e_i2[n] = e_i1[n] + half;
          e_tw[n] = j * groups;
          n++;
        end
      end
    end
  endtask

  // Commit the current cycle at the next posedge, then land at negedge+1
  // with the butterfly writeback for the new cycle applied.
  task automatic drive_cycle();
    bit hs;
    hs  = bf_issue && bf_ready;
    dly = {dly[1:0], hs};
    @(negedge clk);
    bf_wb = wb_auto ? dly[2] : man_wb;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) drive_cycle();
    vectors++;
    if ({busy, done, in_ready, bf_issue, out_valid, err, load_addr, idx1, idx2,
         tw_addr, stage, out_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b in_ready=%b issue=%b out_valid=%b err=%b la=%0d i1=%0d i2=%0d tw=%0d st=%0d oa=%0d, expected all 0",
               busy, done, in_ready, bf_issue, out_valid, err, load_addr, idx1, idx2, tw_addr, stage, out_addr);
    end
    rst_n = 1'b1;
    drive_cycle();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_err_idle();
    man_wb = 1'b1;
    drive_cycle();
    man_wb = 1'b0;
    drive_cycle();
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL err_idle: got err=%b busy=%b expected err=1 busy=0", err, busy);
    end
  endtask

  task automatic test_load(input bit rnd);
    int acc = 0;
    int cyc = 0;
    start = 1'b1;
    drive_cycle();
    start = 1'b0;
    while (acc < N && cyc < 200) begin
      vectors++;
      if (in_ready !== 1'b1 || int'(load_addr) != bitrev(acc)) begin
        miscompares++;
        $display("FAIL load_addr[%0d]: got in_ready=%b addr=%0d expected in_ready=1 addr=%0d",
                 acc, in_ready, load_addr, bitrev(acc));
      end
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_valid) acc++;
      cyc++;
      drive_cycle();
    end
    in_valid = 1'b0;
    if (acc < N) begin
      vectors++;
      miscompares++;
      $display("FAIL load_timeout: got %0d samples expected %0d", acc, N);
    end
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || bf_issue !== 1'b1) begin
      miscompares++;
      $display("FAIL calc_entry: got in_ready=%b busy=%b issue=%b expected 0,1,1",
               in_ready, busy, bf_issue);
    end
    if (!rnd) begin
      vectors++;
      if (cyc != N) begin
        miscompares++;
        $display("FAIL load_latency: got %0d load cycles expected %0d", cyc, N);
      end
    end
  endtask

  task automatic test_calc(input bit rnd);
    int ph = 0;      // 0 issuing, 1 draining, 2 finished
    int st = 0;
    int iss = 0;
    int outs = 0;
    int cyc = 0;
    int dut_hs = 0;
    bit exp_issue;
    bit hs;
    bit w;
    dly = '0;
    wb_auto = 1'b1;
    while (ph != 2 && cyc < 400) begin
      exp_issue = (ph == 0) && (outs < MAX_OUT);
      vectors++;
      if (int'(stage) != st || bf_issue !== exp_issue) begin
        miscompares++;
        $display("FAIL calc_ctrl cyc%0d: got stage=%0d issue=%b expected stage=%0d issue=%b",
                 cyc, stage, bf_issue, st, exp_issue);
      end
      if (exp_issue) begin
        int n = st * HALF + iss;
        vectors++;
        if (int'(idx1) != e_i1[n] || int'(idx2) != e_i2[n] || int'(tw_addr) != e_tw[n]) begin
          miscompares++;
          $display("FAIL bf_addr[%0d]: got (%0d,%0d) tw %0d expected (%0d,%0d) tw %0d",
                   n, idx1, idx2, tw_addr, e_i1[n], e_i2[n], e_tw[n]);
        end
      end
      bf_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bf_issue && bf_ready) dut_hs++;
      hs = exp_issue && bf_ready;
      w  = bf_wb;
      if (ph == 0) begin
        outs = outs + int'(hs) - int'(w);
        if (hs) begin
          iss++;
          if (iss == HALF) ph = 1;
        end
      end else begin
        outs = outs - int'(w);
        if (outs == 0) begin
          if (st < LOG2N - 1) begin
            st++;
            iss = 0;
            ph  = 0;
          end else begin
            ph = 2;
          end
        end
      end
      cyc++;
      drive_cycle();
    end
    bf_ready = 1'b0;
    wb_auto  = 1'b0;
    if (ph != 2) begin
      vectors++;
      miscompares++;
      $display("FAIL calc_timeout: got phase %0d after %0d cycles expected completion", ph, cyc);
    end
    vectors++;
    if (dut_hs != NBF) begin
      miscompares++;
      $display("FAIL handshake_count: got %0d expected %0d", dut_hs, NBF);
    end
    vectors++;
    if (out_valid !== 1'b1 || bf_issue !== 1'b0) begin
      miscompares++;
      $display("FAIL unload_entry: got out_valid=%b issue=%b expected 1,0", out_valid, bf_issue);
    end
  endtask

  task automatic test_unload(input bit rnd, input bit poke_start);
    bit pat [4];
    int cnt = 0;
    int cyc = 0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    while (cnt < N && cyc < 200) begin
      vectors++;
      if (out_valid !== 1'b1 || int'(out_addr) != cnt || busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL unload_beat cyc%0d: got valid=%b addr=%0d busy=%b done=%b expected 1,%0d,1,0",
                 cyc, out_valid, out_addr, busy, done, cnt);
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : pat[cyc % 4];
      start = poke_start && (cyc == 2);
      if (out_ready) cnt++;
      cyc++;
      drive_cycle();
    end
    out_ready = 1'b0;
    start     = 1'b0;
    if (cnt < N) begin
      vectors++;
      miscompares++;
      $display("FAIL unload_timeout: got %0d beats expected %0d", cnt, N);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: got done=%b busy=%b valid=%b expected 1,1,0", done, busy, out_valid);
    end
    drive_cycle();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_end: got done=%b busy=%b expected 0,0", done, busy);
    end
    drive_cycle();
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_done: got busy=%b in_ready=%b done=%b expected 0,0,0",
               busy, in_ready, done);
    end
  endtask

  task automatic test_err_sticky();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b expected 1", err);
    end
  endtask

  // Stage 0 with writebacks held back; MAX_OUT=2 throttles issue.
  task automatic test_max_out();
    bit exp_seq [12];
    bit wb_seq  [12];
    int exp_st  [12];
    // cycles:          A  B  C  D  E  F  G  H  I  J  K  L
    exp_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    wb_seq  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_st  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    wb_auto  = 1'b0;
    man_wb   = 1'b0;
    bf_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      vectors++;
      if (bf_issue !== exp_seq[c] || int'(stage) != exp_st[c]) begin
        miscompares++;
        $display("FAIL max_out cyc%0d: got issue=%b stage=%0d expected issue=%b stage=%0d",
                 c, bf_issue, stage, exp_seq[c], exp_st[c]);
      end
      if (c == 11) break;
      man_wb = wb_seq[c];
      drive_cycle();
    end
    man_wb = 1'b0;
  endtask

  task automatic test_async_reset();
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, in_ready, bf_issue, out_valid, err, load_addr, idx1, idx2,
         tw_addr, stage, out_addr} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got busy=%b issue=%b err=%b i1=%0d i2=%0d tw=%0d st=%0d, expected all 0",
               busy, bf_issue, err, idx1, idx2, tw_addr, stage);
    end
    bf_ready = 1'b0;
    repeat (2) drive_cycle();
    rst_n = 1'b1;
    drive_cycle();
    vectors++;
    if (busy !== 1'b0 || bf_issue !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got busy=%b issue=%b err=%b expected 0,0,0",
               busy, bf_issue, err);
    end
  endtask

  initial begin
    build_expected();
    test_reset();
    test_err_idle();
    test_load(1'b0);
    test_calc(1'b0);
    test_unload(1'b0, 1'b1);
    test_err_sticky();
    test_load(1'b1);
    test_calc(1'b1);
    test_unload(1'b1, 1'b0);
    test_load(1'b1);
    test_max_out();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
